// File: rtl/md_cell_pkg.sv
// md_cell_pkg
// Shared types for the molecular-dynamics cell storage blocks.
//   POS_WIDTH / DATA_WIDTH : coordinate width and packed {z, y, x} word width
//   pos_t                  : one particle position, MSB->LSB {z, y, x}
//   bank_sel_t             : index of one of the two position banks
package md_cell_pkg;

    localparam int POS_WIDTH  = 32;
    localparam int DATA_WIDTH = 3 * POS_WIDTH;

    typedef struct packed {
        logic [POS_WIDTH-1:0] z;
        logic [POS_WIDTH-1:0] y;
        logic [POS_WIDTH-1:0] x;
    } pos_t;

    typedef logic bank_sel_t;

    function automatic bank_sel_t other_bank(input bank_sel_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/pos_bank_ram.sv
// pos_bank_ram
// Simple dual-port position RAM: one synchronous write port, one read port
// with a registered address and a registered output (two-cycle read).
// No reset: contents and read pipeline are pure data.
//   clk                        clock
//   wr_en / wr_addr / wr_data  write port, committed at the clock edge
//   rd_en / rd_addr            read request; data appears two cycles later
//   rd_data                    registered read data
// INIT_FILE names the hex image that the build flow attaches to the
// memory as its power-up contents ("" leaves it zero-filled).
module pos_bank_ram #(
    parameter int    DATA_WIDTH = 96,
    parameter int    DEPTH      = 220,
    parameter int    ADDR_WIDTH = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  rd_en_p1_q,   rd_en_p1_d;
    logic [ADDR_WIDTH-1:0] rd_addr_p1_q, rd_addr_p1_d;
    logic [DATA_WIDTH-1:0] rd_data_p2_q, rd_data_p2_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // p0 -> p1: register the read address
    always_comb begin
        rd_en_p1_d   = rd_en;
        rd_addr_p1_d = rd_en ? rd_addr : rd_addr_p1_q;
    end

    // p1 -> p2: register the array output
    always_comb begin
        rd_data_p2_d = rd_en_p1_q ? mem_q[rd_addr_p1_q] : rd_data_p2_q;
    end

    always_ff @(posedge clk) begin
        rd_en_p1_q   <= rd_en_p1_d;
        rd_addr_p1_q <= rd_addr_p1_d;
        rd_data_p2_q <= rd_data_p2_d;
    end

    assign rd_data = rd_data_p2_q;

endmodule

// File: rtl/cell_pos_buffer.sv
// cell_pos_buffer
// Double-buffered particle-position store for one cell. The active bank
// serves force-pipeline reads; motion update appends into the shadow bank;
// a swap pulse exchanges the banks at the time-step boundary.
//   clk, rst                      clock, synchronous active-high reset
//   rd_en, rd_addr                read request (addr 0 = particle count)
//   rd_data, rd_valid             read result, two cycles after rd_en
//   wr_valid, wr_data, wr_ready   append into the shadow bank
//   swap                          one-cycle pulse, exchange banks
//   active_count, shadow_count    particles held in each bank
//   overflow                      sticky: append attempted while full
module cell_pos_buffer
    import md_cell_pkg::*;
#(
    parameter int    POS_WIDTH    = 32,
    parameter int    DATA_WIDTH   = 3 * POS_WIDTH,
    parameter int    PARTICLE_NUM = 220,
    parameter int    ADDR_WIDTH   = 8,
    parameter int    INIT_COUNT   = 0,
    parameter string INIT_FILE    = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  swap,
    output logic [ADDR_WIDTH-1:0] active_count,
    output logic [ADDR_WIDTH-1:0] shadow_count,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH-1:0] MAX_CNT  = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] INIT_CNT = ADDR_WIDTH'(INIT_COUNT);
    localparam logic                  READY_RST = (PARTICLE_NUM > 1);

    // Final read-result selection: count word, stored word or forced zero.
    function automatic logic [DATA_WIDTH-1:0] read_mux(
        input logic                  vld,
        input logic                  is_cnt,
        input logic                  in_range,
        input logic [ADDR_WIDTH-1:0] cnt,
        input logic [DATA_WIDTH-1:0] word
    );
        if (!vld)     return '0;
        if (is_cnt)   return DATA_WIDTH'(cnt);
        if (in_range) return word;
        return '0;
    endfunction

    // ------------------------------------------------------------------
    // Bank / count control
    // ------------------------------------------------------------------
    bank_sel_t             bank_sel_q, bank_sel_d;
    bank_sel_t             sh_bank;
    logic [ADDR_WIDTH-1:0] cnt_q [2];
    logic [ADDR_WIDTH-1:0] cnt_d [2];
    logic                  overflow_q, overflow_d;
    logic                  wr_ready_q, wr_ready_d;
    logic [ADDR_WIDTH-1:0] act_cnt;
    logic [ADDR_WIDTH-1:0] sh_cnt;
    logic [ADDR_WIDTH-1:0] sh_cnt_inc;
    logic                  wr_fire;

    assign sh_bank    = other_bank(bank_sel_q);
    assign act_cnt    = cnt_q[bank_sel_q];
    assign sh_cnt     = cnt_q[sh_bank];
    assign sh_cnt_inc = sh_cnt + 1'b1;
    assign wr_fire    = wr_valid & wr_ready_q;

    always_comb begin
        bank_sel_d = bank_sel_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | (wr_valid & ~wr_ready_q);

        // The append lands in the old shadow bank before any swap, so a
        // same-cycle swap hands over a count that already includes it.
        if (wr_fire) begin
            cnt_d[sh_bank] = sh_cnt_inc;
        end
        if (swap) begin
            bank_sel_d        = sh_bank;
            cnt_d[bank_sel_q] = '0;
        end

        wr_ready_d = (cnt_d[other_bank(bank_sel_d)] < MAX_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel_q <= 1'b0;
            cnt_q[0]   <= INIT_CNT;
            cnt_q[1]   <= '0;
            overflow_q <= 1'b0;
            wr_ready_q <= READY_RST;
        end else begin
            bank_sel_q <= bank_sel_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            overflow_q <= overflow_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    assign active_count = act_cnt;
    assign shadow_count = sh_cnt;
    assign overflow     = overflow_q;
    assign wr_ready     = wr_ready_q;

    // ------------------------------------------------------------------
    // Banks: shared read address, per-bank write enable
    // ------------------------------------------------------------------
    logic                  we_b0, we_b1;
    logic [DATA_WIDTH-1:0] ram_dout_b0, ram_dout_b1;

    assign we_b0 = wr_fire & (sh_bank == 1'b0);
    assign we_b1 = wr_fire & (sh_bank == 1'b1);

    pos_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (PARTICLE_NUM),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_bank0 (
        .clk     (clk),
        .wr_en   (we_b0),
        .wr_addr (sh_cnt_inc),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_dout_b0)
    );

    pos_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (PARTICLE_NUM),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  ("")
    ) u_bank1 (
        .clk     (clk),
        .wr_en   (we_b1),
        .wr_addr (sh_cnt_inc),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_dout_b1)
    );

    // ------------------------------------------------------------------
    // Read side-band pipeline, aligned with the two RAM stages
    // ------------------------------------------------------------------
    logic                  vld_p1_q,      vld_p1_d;
    bank_sel_t             bank_p1_q,     bank_p1_d;
    logic                  is_cnt_p1_q,   is_cnt_p1_d;
    logic                  in_range_p1_q, in_range_p1_d;
    logic [ADDR_WIDTH-1:0] cnt_p1_q,      cnt_p1_d;

    logic                  vld_p2_q,      vld_p2_d;
    bank_sel_t             bank_p2_q,     bank_p2_d;
    logic                  is_cnt_p2_q,   is_cnt_p2_d;
    logic                  in_range_p2_q, in_range_p2_d;
    logic [ADDR_WIDTH-1:0] cnt_p2_q,      cnt_p2_d;

    // p0 -> p1: bank and count are frozen in the issue cycle
    always_comb begin
        vld_p1_d      = rd_en;
        bank_p1_d     = bank_sel_q;
        is_cnt_p1_d   = (rd_addr == '0);
        in_range_p1_d = (rd_addr != '0) && (rd_addr <= act_cnt);
        cnt_p1_d      = act_cnt;
    end

    // p1 -> p2
    always_comb begin
        vld_p2_d      = vld_p1_q;
        bank_p2_d     = bank_p1_q;
        is_cnt_p2_d   = is_cnt_p1_q;
        in_range_p2_d = in_range_p1_q;
        cnt_p2_d      = cnt_p1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    always_ff @(posedge clk) begin
        bank_p1_q     <= bank_p1_d;
        is_cnt_p1_q   <= is_cnt_p1_d;
        in_range_p1_q <= in_range_p1_d;
        cnt_p1_q      <= cnt_p1_d;
        bank_p2_q     <= bank_p2_d;
        is_cnt_p2_q   <= is_cnt_p2_d;
        in_range_p2_q <= in_range_p2_d;
        cnt_p2_q      <= cnt_p2_d;
    end

    // p2: output select
    logic [DATA_WIDTH-1:0] ram_word_p2;

    assign ram_word_p2 = bank_p2_q ? ram_dout_b1 : ram_dout_b0;
    assign rd_valid    = vld_p2_q;
    assign rd_data     = read_mux(vld_p2_q, is_cnt_p2_q, in_range_p2_q,
                                  cnt_p2_q, ram_word_p2);

endmodule

// File: tb/tb_cell_pos_buffer.sv
module tb_cell_pos_buffer;
    import md_cell_pkg::*;

    localparam int PN       = 220;
    localparam int AW       = 8;
    localparam int DW       = 96;
    localparam int INIT_CNT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          swap = 1'b0;
    logic [AW-1:0] active_count;
    logic [AW-1:0] shadow_count;
    logic          overflow;

    cell_pos_buffer #(
        .POS_WIDTH    (32),
        .DATA_WIDTH   (DW),
        .PARTICLE_NUM (PN),
        .ADDR_WIDTH   (AW),
        .INIT_COUNT   (INIT_CNT),
        .INIT_FILE    ("")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .swap         (swap),
        .active_count (active_count),
        .shadow_count (shadow_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard of outstanding reads
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Table of read vectors
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } rd_vec_t;
    rd_vec_t rst_vec [4];
    rd_vec_t abc_vec [6];

    // Behavioural reference model
    logic [DW-1:0] m_mem [2][256];
    int            m_cnt [2];
    int            m_sel;
    logic          m_ovf;

    logic [DW-1:0] WA, WB, WC, WD, WE, WF;
    logic [DW-1:0] first_w, last_w, rnd_w;

    function automatic logic [DW-1:0] mk_pos(input logic [31:0] z, input logic [31:0] y,
                                             input logic [31:0] x);
        pos_t p;
        p.z = z;
        p.y = y;
        p.x = x;
        return p;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_ctrl(input string name);
        check({name, "_active_count"}, DW'(active_count), DW'(m_cnt[m_sel]));
        check({name, "_shadow_count"}, DW'(shadow_count), DW'(m_cnt[1 - m_sel]));
        check({name, "_wr_ready"}, DW'(wr_ready), DW'(m_cnt[1 - m_sel] < PN - 1));
        check({name, "_overflow"}, DW'(overflow), DW'(m_ovf));
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_missing: no rd_valid at cycle %0d, expected data %h",
                     sb_q[0].due, sb_q[0].data);
            void'(sb_q.pop_front());
        end
        if (rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: rd_valid=1 data %h at cycle %0d, expected no read",
                         rd_data, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("rd_latency", DW'(cyc), DW'(mon_e.due));
                check("rd_data", rd_data, mon_e.data);
            end
        end
    end

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a == '0) return DW'(m_cnt[m_sel]);
        if (int'(a) <= m_cnt[m_sel]) return m_mem[m_sel][a];
        return '0;
    endfunction

    task automatic drive(input logic re, input logic [AW-1:0] ra, input logic wv,
                         input logic [DW-1:0] wd, input logic sw);
        rd_en    = re;
        rd_addr  = ra;
        wr_valid = wv;
        wr_data  = wd;
        swap     = sw;
    endtask

    task automatic push_exp(input logic [DW-1:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 2;
        sb_q.push_back(e);
    endtask

    // Advance one clock, updating the model with the inputs being driven.
    task automatic step();
        int sh;
        if (rst) begin
            m_sel    = 0;
            m_cnt[0] = INIT_CNT;
            m_cnt[1] = 0;
            m_ovf    = 1'b0;
        end else begin
            sh = 1 - m_sel;
            if (wr_valid) begin
                if (m_cnt[sh] < PN - 1) begin
                    m_cnt[sh]++;
                    m_mem[sh][m_cnt[sh]] = wr_data;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (swap) begin
                m_cnt[m_sel] = 0;
                m_sel        = sh;
            end
        end
        @(posedge clk);
        #1;
        rd_en    = 1'b0;
        wr_valid = 1'b0;
        swap     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        WA = mk_pos(32'h3f80_0000, 32'h4000_0000, 32'h4040_0000);
        WB = mk_pos(32'h4080_0000, 32'h40a0_0000, 32'h40c0_0000);
        WC = mk_pos(32'hbf80_0000, 32'hc000_0000, 32'hc040_0000);
        WD = mk_pos(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        WE = mk_pos(32'h4444_4444, 32'h5555_5555, 32'h6666_6666);
        WF = mk_pos(32'h7777_7777, 32'h8888_8888, 32'h9999_9999);

        rst_vec[0] = '{addr: 8'd0,   exp: DW'(3)};
        rst_vec[1] = '{addr: 8'd4,   exp: '0};
        rst_vec[2] = '{addr: 8'd200, exp: '0};
        rst_vec[3] = '{addr: 8'd0,   exp: DW'(3)};

        abc_vec[0] = '{addr: 8'd1,   exp: WA};
        abc_vec[1] = '{addr: 8'd2,   exp: WB};
        abc_vec[2] = '{addr: 8'd3,   exp: WC};
        abc_vec[3] = '{addr: 8'd0,   exp: DW'(3)};
        abc_vec[4] = '{addr: 8'd4,   exp: '0};
        abc_vec[5] = '{addr: 8'd255, exp: '0};

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_active_count", DW'(active_count), DW'(3));
        check("rst_shadow_count", DW'(shadow_count), '0);
        check("rst_wr_ready", DW'(wr_ready), DW'(1));
        check("rst_overflow", DW'(overflow), '0);
        check("rst_rd_valid", DW'(rd_valid), '0);
        check("rst_rd_data", rd_data, '0);

        // Count / out-of-range reads on the initial bank
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rst_vec[i].addr, 1'b0, '0, 1'b0);
            push_exp(rst_vec[i].exp);
            step();
        end
        idle(4);

        // Append A, B, C then swap
        drive(1'b0, '0, 1'b1, WA, 1'b0); step();
        drive(1'b0, '0, 1'b1, WB, 1'b0); step();
        drive(1'b0, '0, 1'b1, WC, 1'b0); step();
        check("abc_shadow_count", DW'(shadow_count), DW'(3));
        check_ctrl("abc");
        drive(1'b0, '0, 1'b0, '0, 1'b1); step();
        check("swap_active_count", DW'(active_count), DW'(3));
        check("swap_shadow_count", DW'(shadow_count), '0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, abc_vec[i].addr, 1'b0, '0, 1'b0);
            push_exp(abc_vec[i].exp);
            step();
        end
        idle(4);

        // Two appends, then append + swap + read in the same cycle
        drive(1'b0, '0, 1'b1, WD, 1'b0); step();
        drive(1'b0, '0, 1'b1, WE, 1'b0); step();
        drive(1'b1, 8'd1, 1'b1, WF, 1'b1);
        push_exp(WA);
        step();
        check("wswap_active_count", DW'(active_count), DW'(3));
        check("wswap_shadow_count", DW'(shadow_count), '0);
        drive(1'b1, 8'd1, 1'b0, '0, 1'b0); push_exp(WD); step();
        drive(1'b1, 8'd3, 1'b0, '0, 1'b0); push_exp(WF); step();
        drive(1'b1, 8'd0, 1'b0, '0, 1'b0); push_exp(model_read(8'd0)); step();
        idle(4);
        check_ctrl("wswap");

        // Fill the shadow bank to capacity, then overflow
        first_w = '0;
        last_w  = '0;
        for (int i = 0; i < PN - 1; i++) begin
            rnd_w = {$urandom(), $urandom(), $urandom()};
            if (i == 0) first_w = rnd_w;
            last_w = rnd_w;
            drive(1'b0, '0, 1'b1, rnd_w, 1'b0);
            step();
            if (i == PN - 3) check("fill_wr_ready_before_last", DW'(wr_ready), DW'(1));
        end
        check("full_wr_ready", DW'(wr_ready), '0);
        check("full_shadow_count", DW'(shadow_count), DW'(219));
        check("full_overflow", DW'(overflow), '0);
        drive(1'b0, '0, 1'b1, {3{32'hdead_beef}}, 1'b0);
        step();
        check("ovf_overflow", DW'(overflow), DW'(1));
        check("ovf_shadow_count", DW'(shadow_count), DW'(219));
        check_ctrl("ovf");
        drive(1'b0, '0, 1'b0, '0, 1'b1); step();
        check("full_swap_active_count", DW'(active_count), DW'(219));
        drive(1'b1, 8'd219, 1'b0, '0, 1'b0); push_exp(last_w);  step();
        drive(1'b1, 8'd1,   1'b0, '0, 1'b0); push_exp(first_w); step();
        drive(1'b1, 8'd220, 1'b0, '0, 1'b0); push_exp('0);      step();
        idle(4);

        // Reset with two reads in flight
        drive(1'b1, 8'd0, 1'b0, '0, 1'b0); step();
        drive(1'b1, 8'd1, 1'b0, '0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_rd_valid_0", DW'(rd_valid), '0);
        step();
        check("midrst_rd_valid_1", DW'(rd_valid), '0);
        check("midrst_active_count", DW'(active_count), DW'(3));
        check("midrst_shadow_count", DW'(shadow_count), '0);
        check("midrst_overflow", DW'(overflow), '0);
        check("midrst_wr_ready", DW'(wr_ready), DW'(1));
        drive(1'b1, 8'd0, 1'b0, '0, 1'b0); push_exp(DW'(3)); step();
        idle(4);

        check("sb_drained", DW'(sb_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
